// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises {opcode, payload} frames from mosi and serialises RAM read
// data onto miso. Define PARITY_EN to append an even-parity bit to every frame.
module spi_slave_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
`ifdef PARITY_EN
    output logic              parity_err,
`endif
    output logic              frame_err
);

`ifdef PARITY_EN
    localparam bit          HasParity = 1'b1;
    localparam int unsigned FrameBits = DATA_W + 3;
`else
    localparam bit          HasParity = 1'b0;
    localparam int unsigned FrameBits = DATA_W + 2;
`endif
    localparam int unsigned BitCntW = $clog2(FrameBits);
    localparam int unsigned TxCntW  = $clog2(DATA_W);

    localparam logic [BitCntW-1:0] BitCntInit = BitCntW'(FrameBits - 1);
    localparam logic [TxCntW-1:0]  TxCntInit  = TxCntW'(DATA_W - 1);
    localparam logic [7:0]         WaitLast   = 8'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StChkCmd, StWrite, StReadAdd, StReadData} state_e;
    typedef enum logic [1:0] {PhCapture, PhTxWait, PhTxShift, PhHold} phase_e;

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic [DATA_W+1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W+1:0]   rx_data_q, rx_data_d;
    logic                miso_q, miso_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                rd_pend_q, rd_pend_d;
    logic                valid_pend_q, valid_pend_d;
    logic                perr_pend_q, perr_pend_d;
    logic                last_bit;
    logic                payload_ok;

    assign last_bit   = (bit_cnt_q == '0);
    // With parity the final sampled bit is the parity bit and is never shifted in.
    assign payload_ok = HasParity ? ~(^{shift_q, mosi}) : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            phase_q      <= PhCapture;
            bit_cnt_q    <= BitCntInit;
            tx_cnt_q     <= TxCntInit;
            wait_cnt_q   <= '0;
            shift_q      <= '0;
            tx_sr_q      <= '0;
            rx_data_q    <= '0;
            miso_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            valid_pend_q <= 1'b0;
            perr_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            shift_q      <= shift_d;
            tx_sr_q      <= tx_sr_d;
            rx_data_q    <= rx_data_d;
            miso_q       <= miso_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rd_pend_q    <= rd_pend_d;
            valid_pend_q <= valid_pend_d;
            perr_pend_q  <= perr_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        shift_d      = shift_q;
        tx_sr_d      = tx_sr_q;
        miso_d       = miso_q;
        rd_pend_d    = rd_pend_q;
        valid_pend_d = 1'b0;
        perr_pend_d  = 1'b0;
        // Completion is reported one cycle after the last bit, even if ss_n rose meanwhile.
        rx_valid_d   = valid_pend_q;
        rx_data_d    = valid_pend_q ? shift_q : rx_data_q;
        frame_err_d  = perr_pend_q;

        unique case (state_q)
            StIdle: begin
                if (!ss_n) state_d = StChkCmd;
            end
            StChkCmd: begin
                phase_d = PhCapture;
                if (!mosi)          state_d = StWrite;
                else if (rd_pend_q) state_d = StReadData;
                else                state_d = StReadAdd;
            end
            default: begin
                unique case (phase_q)
                    PhCapture: begin
                        if (!(HasParity && last_bit)) shift_d = {shift_q[DATA_W:0], mosi};
                        if (last_bit) begin
                            bit_cnt_d    = BitCntInit;
                            valid_pend_d = payload_ok;
                            perr_pend_d  = ~payload_ok;
                            wait_cnt_d   = '0;
                            if (payload_ok && state_q == StReadAdd) rd_pend_d = 1'b1;
                            phase_d = (payload_ok && state_q == StReadData) ? PhTxWait : PhHold;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end
                    end
                    PhTxWait: begin
                        // The cycle that raises rx_valid is still part of capture.
                        if (!valid_pend_q) begin
                            if (tx_valid) begin
                                tx_sr_d  = tx_data;
                                miso_d   = tx_data[DATA_W-1];
                                tx_cnt_d = TxCntInit;
                                phase_d  = PhTxShift;
                            end else if (wait_cnt_q == WaitLast) begin
                                frame_err_d = 1'b1;
                                rd_pend_d   = 1'b0;
                                phase_d     = PhHold;
                            end else begin
                                wait_cnt_d = wait_cnt_q + 1'b1;
                            end
                        end
                    end
                    PhTxShift: begin
                        if (tx_cnt_q == '0) begin
                            miso_d    = 1'b0;
                            rd_pend_d = 1'b0;
                            phase_d   = PhHold;
                        end else begin
                            miso_d   = tx_sr_q[tx_cnt_q - 1'b1];
                            tx_cnt_d = tx_cnt_q - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        endcase

        if (ss_n && state_q != StIdle) begin
            state_d    = StIdle;
            phase_d    = PhCapture;
            bit_cnt_d  = BitCntInit;
            tx_cnt_d   = TxCntInit;
            wait_cnt_d = '0;
            miso_d     = 1'b0;
            if (state_q == StChkCmd || (phase_q == PhCapture && !last_bit)) frame_err_d = 1'b1;
            // An interrupted read-data transfer keeps its address so the master can retry.
            if (phase_q == PhTxShift) begin
                frame_err_d = 1'b1;
                rd_pend_d   = rd_pend_q;
            end
        end
    end

`ifdef PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= perr_pend_q;
    end

    assign parity_err = parity_err_q;
`endif

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised bench for spi_slave_param: per-frame expected waveforms are derived from the
// frame rules (event cycles, read-pending flag) and compared every cycle.
module tb_spi_slave_param;
    localparam int DW   = 8;
    localparam int TO   = 16;
    localparam int VCYC = DW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ss_n;
    logic          mosi;
    logic          miso;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          busy;
    logic          frame_err;

    int            checks = 0;
    int            errors = 0;
    bit            pend;
    logic [DW+1:0] m_rxd;

    spi_slave_param #(
        .DATA_W    (DW),
        .TX_TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // len: first edge at which ss_n is sampled high; edge 0 is the first ss_n-low edge.
    task automatic run_frame(input int id, input bit rw, input logic [DW+1:0] pay, input int len_in,
                             input int tx_dly, input logic [DW-1:0] txd, input int rst_at);
        bit            e_rxv[64];
        bit            e_fe[64];
        bit            e_miso[64];
        bit            e_busy[64];
        logic [DW+1:0] e_rxd[64];
        bit            complete, rd_data, is_rst, noise_ok;
        int            n, le, len;
        logic [DW+1:0] cur;

        len      = len_in;
        is_rst   = (rst_at >= 0);
        if (is_rst) len = rst_at + 1;
        complete = !is_rst && (len >= DW + 3);
        rd_data  = rw && pend;
        n        = (len + 2 > VCYC + 2) ? len + 2 : VCYC + 2;
        le       = (tx_dly >= 0) ? VCYC + 1 + tx_dly : -1;
        cur      = m_rxd;

        for (int t = 0; t < 64; t++) begin
            e_rxv[t]  = 1'b0;
            e_fe[t]   = 1'b0;
            e_miso[t] = 1'b0;
            e_busy[t] = is_rst ? (t < rst_at) : (t < len);
            if (complete && t == VCYC) cur = pay;
            if (is_rst && t >= rst_at) cur = '0;
            e_rxd[t] = cur;
        end
        m_rxd = cur;

        if (complete) e_rxv[VCYC] = 1'b1;
        else if (!is_rst) e_fe[len] = 1'b1;
        if (is_rst) pend = 1'b0;
        if (complete && rw && !rd_data) pend = 1'b1;
        if (complete && rd_data) begin
            if (le < 0) begin
                e_fe[VCYC + TO] = 1'b1;
                pend = 1'b0;
            end else begin
                for (int k = 0; k < DW; k++)
                    if (le + k < len) e_miso[le + k] = txd[DW-1-k];
                if (len <= le + DW) e_fe[len] = 1'b1;
                else pend = 1'b0;
            end
        end

        for (int e = 0; e < n; e++) begin
            ss_n  = (e >= len);
            rst_n = !(is_rst && e == rst_at);
            if (e == 1)                    mosi = rw;
            else if (e >= 2 && e <= DW + 3) mosi = pay[DW+3-e];
            else                           mosi = 1'($urandom);
            if (le >= 0 && e == le) begin
                tx_valid = 1'b1;
                tx_data  = txd;
            end else begin
                tx_data = DW'($urandom);
                if (!(complete && rd_data)) noise_ok = 1'b1;
                else if (le >= 0)           noise_ok = (e <= VCYC) || (e > le);
                else                        noise_ok = (e <= VCYC) || (e > VCYC + TO);
                tx_valid = noise_ok ? 1'($urandom) : 1'b0;
            end
            @(posedge clk);
            #1;
            check_val($sformatf("f%0d c%0d rx_valid", id, e), rx_valid, e_rxv[e]);
            check_val($sformatf("f%0d c%0d frame_err", id, e), frame_err, e_fe[e]);
            check_val($sformatf("f%0d c%0d miso", id, e), miso, e_miso[e]);
            check_val($sformatf("f%0d c%0d busy", id, e), busy, e_busy[e]);
            check_val($sformatf("f%0d c%0d rx_data", id, e), rx_data, e_rxd[e]);
        end
        ss_n     = 1'b1;
        rst_n    = 1'b1;
        tx_valid = 1'b0;
    endtask

    initial begin
        bit            rw;
        logic [DW+1:0] pay;
        logic [DW-1:0] txd;
        int            kind, d, len, dly;

        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        pend     = 1'b0;
        m_rxd    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset miso", miso, 1'b0);
        check_val("reset rx_data", rx_data, '0);
        check_val("reset rx_valid", rx_valid, 1'b0);
        check_val("reset busy", busy, 1'b0);
        check_val("reset frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(1, 1'b0, 10'h0A5, 14, -1, 8'h00, -1);              // write
        run_frame(2, 1'b1, 10'h233, 14, -1, 8'h00, -1);              // read address
        run_frame(3, 1'b1, 10'h300, VCYC + 3 + DW + 2, 2, 8'hC3, -1); // read data
        run_frame(4, 1'b0, 10'h155, 7, -1, 8'h00, -1);               // abort after 5 bits
        run_frame(5, 1'b1, 10'h0F0, 14, -1, 8'h00, -1);
        run_frame(6, 1'b1, 10'h3FF, VCYC + TO + 3, -1, 8'h00, -1);   // tx timeout
        run_frame(7, 1'b1, 10'h2AA, 0, -1, 8'h00, 6);                // reset mid read address
        run_frame(8, 1'b1, 10'h1C7, 22, 3, 8'h5A, -1);               // must be read address
        run_frame(9, 1'b0, 10'h3C3, DW + 3, -1, 8'h00, -1);          // ss_n rises on last bit
        run_frame(10, 1'b1, 10'h000, 1, -1, 8'h00, -1);              // abort in command phase
        run_frame(11, 1'b1, 10'h311, VCYC + 8, 4, 8'hA5, -1);        // abort during tx
        run_frame(12, 1'b1, 10'h311, VCYC + 2 + DW + 1, 1, 8'h96, -1); // retried read data

        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom);
            pay  = (DW + 2)'($urandom);
            txd  = DW'($urandom);
            kind = $urandom_range(0, 3);
            d    = $urandom_range(1, TO - 2);
            case (kind)
                0: begin
                    dly = -1;
                    len = $urandom_range(1, DW + 2);
                end
                1: begin
                    dly = d;
                    len = VCYC + 1 + d + DW + 1 + $urandom_range(0, 3);
                end
                2: begin
                    dly = -1;
                    len = VCYC + TO + 1 + $urandom_range(0, 3);
                end
                default: begin
                    dly = d;
                    len = VCYC + 1 + d + 1 + $urandom_range(0, DW - 2);
                end
            endcase
            run_frame(100 + i, rw, pay, len, dly, txd, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
